// File: rtl/memory_arbiter.sv
// Per-cycle arbiter sharing one synchronous-read memory between the CPU and the IOP.
// IOP has fixed priority; a lock holds the bus for RMW and a starvation counter bounds CPU wait.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         cpu_req,
    input  logic         cpu_lock,
    input  logic [15:31] cpu_address,
    input  logic [0:3]   cpu_write_en,
    input  logic [0:31]  cpu_data,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,

    input  logic         iop_req,
    input  logic         iop_lock,
    input  logic [15:31] iop_address,
    input  logic [0:3]   iop_write_en,
    input  logic [0:31]  iop_data,
    output logic         iop_gnt,
    output logic         iop_rvalid,

    output logic [15:31] memory_address,
    output logic [0:3]   mem_write_en,
    output logic [0:31]  memory_data_in,
    output logic         cpu_active
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IOP = 1'b1
    } owner_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    owner_e           owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rvalid_cpu_q, rvalid_iop_q;

    // Grant priority: lock hold, then starvation relief, then IOP, then CPU.
    always_comb begin
        cpu_gnt = 1'b0;
        iop_gnt = 1'b0;
        if (locked_q && owner_q == OWN_CPU && cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (locked_q && owner_q == OWN_IOP && iop_req) begin
            iop_gnt = 1'b1;
        end else if (starve_q >= LIMIT && cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (iop_req) begin
            iop_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end
    end

    always_comb begin
        memory_address = '0;
        mem_write_en   = '0;
        memory_data_in = '0;
        if (cpu_gnt) begin
            memory_address = cpu_address;
            mem_write_en   = cpu_write_en;
            memory_data_in = cpu_data;
        end else if (iop_gnt) begin
            memory_address = iop_address;
            mem_write_en   = iop_write_en;
            memory_data_in = iop_data;
        end
    end

    always_comb begin
        owner_d  = owner_q;
        locked_d = 1'b0;
        if (cpu_gnt) begin
            owner_d  = OWN_CPU;
            locked_d = cpu_lock;
        end else if (iop_gnt) begin
            owner_d  = OWN_IOP;
            locked_d = iop_lock;
        end

        starve_d = '0;
        if (cpu_req && !cpu_gnt) begin
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            locked_q     <= 1'b0;
            starve_q     <= '0;
            rvalid_cpu_q <= 1'b0;
            rvalid_iop_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            locked_q     <= locked_d;
            starve_q     <= starve_d;
            rvalid_cpu_q <= cpu_gnt;
            rvalid_iop_q <= iop_gnt;
        end
    end

    assign cpu_rvalid = rvalid_cpu_q;
    assign iop_rvalid = rvalid_iop_q;
    assign cpu_active = (owner_q == OWN_CPU);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter, with a synchronous-read memory
// attached and a rule-level reference model of grants, ownership and memory contents.
module tb_memory_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int SAT          = 7;

    typedef struct packed {
        logic         req;
        logic         lock;
        logic [15:31] addr;
        logic [0:3]   we;
        logic [0:31]  data;
    } req_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0, cpu_lock = 1'b0;
    logic [15:31] cpu_address = '0;
    logic [0:3]   cpu_write_en = '0;
    logic [0:31]  cpu_data = '0;
    logic         iop_req = 1'b0, iop_lock = 1'b0;
    logic [15:31] iop_address = '0;
    logic [0:3]   iop_write_en = '0;
    logic [0:31]  iop_data = '0;
    logic         cpu_gnt, cpu_rvalid, iop_gnt, iop_rvalid, cpu_active;
    logic [15:31] memory_address;
    logic [0:3]   mem_write_en;
    logic [0:31]  memory_data_in;

    memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_address(cpu_address),
        .cpu_write_en(cpu_write_en), .cpu_data(cpu_data),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .iop_req(iop_req), .iop_lock(iop_lock), .iop_address(iop_address),
        .iop_write_en(iop_write_en), .iop_data(iop_data),
        .iop_gnt(iop_gnt), .iop_rvalid(iop_rvalid),
        .memory_address(memory_address), .mem_write_en(mem_write_en),
        .memory_data_in(memory_data_in), .cpu_active(cpu_active)
    );

    always #5 clock = ~clock;

    function automatic logic [0:31] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'h1234_5678 : (32'hA500_0000 | 32'(a));
    endfunction

    // Attached memory: samples address/write on the rising edge, read-before-write.
    logic [0:31] mem [0:255];
    bit          written [0:255];
    logic [0:31] mem_dout;
    logic [0:31] mem_cur;
    always @(posedge clock) begin
        mem_cur  = written[memory_address[24:31]] ? mem[memory_address[24:31]]
                                                  : init_word(memory_address[24:31]);
        mem_dout <= mem_cur;
        if (|mem_write_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_write_en[b]) mem_cur[8*b +: 8] = memory_data_in[8*b +: 8];
            mem[memory_address[24:31]]     <= mem_cur;
            written[memory_address[24:31]] <= 1'b1;
        end
    end

    // Reference model state: who holds a lock (0 none, 1 CPU, 2 IOP), last grantee, CPU wait count.
    logic [0:31] ref_mem [0:255];
    int          m_lock;
    bit          m_owner_cpu;
    int          m_wait;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        obs_cgnt, obs_ignt;
    logic [0:3]  obs_we;
    logic [15:31] obs_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_lock = 0;
        m_owner_cpu = 1'b1;
        m_wait = 0;
    endtask

    function automatic int model_grant(input logic creq, input logic ireq);
        if (m_lock == 1 && creq) return 1;
        if (m_lock == 2 && ireq) return 2;
        if (m_wait >= STARVE_LIMIT && creq) return 1;
        if (ireq) return 2;
        if (creq) return 1;
        return 0;
    endfunction

    // Entered at posedge+1: drive, check combinational outputs, cross the edge, check registered ones.
    task automatic step(input req_t c, input req_t i);
        int          g;
        req_t        sel;
        logic [0:31] exp_rd;
        cpu_req = c.req; cpu_lock = c.lock; cpu_address = c.addr;
        cpu_write_en = c.we; cpu_data = c.data;
        iop_req = i.req; iop_lock = i.lock; iop_address = i.addr;
        iop_write_en = i.we; iop_data = i.data;
        #2;
        g = model_grant(c.req, i.req);
        sel = (g == 1) ? c : (g == 2) ? i : '0;
        check_eq("cpu_gnt", cpu_gnt, g == 1);
        check_eq("iop_gnt", iop_gnt, g == 2);
        check_eq("mem_addr", memory_address, sel.addr);
        check_eq("mem_we", mem_write_en, sel.we);
        check_eq("mem_din", memory_data_in, (sel.we != 0) ? sel.data : (g != 0 ? sel.data : '0));
        obs_cgnt = cpu_gnt; obs_ignt = iop_gnt; obs_we = mem_write_en; obs_addr = memory_address;

        exp_rd = ref_mem[sel.addr[24:31]];
        if (g != 0) begin
            for (int b = 0; b < 4; b++)
                if (sel.we[b]) ref_mem[sel.addr[24:31]][8*b +: 8] = sel.data[8*b +: 8];
            m_owner_cpu = (g == 1);
            m_lock = sel.lock ? g : 0;
        end else begin
            m_lock = 0;
        end
        if (c.req && g != 1) m_wait = (m_wait < SAT) ? m_wait + 1 : SAT;
        else m_wait = 0;

        @(posedge clock); #1;
        check_eq("cpu_rvalid", cpu_rvalid, g == 1);
        check_eq("iop_rvalid", iop_rvalid, g == 2);
        check_eq("cpu_active", cpu_active, m_owner_cpu);
        if (g != 0) check_eq("rdata", mem_dout, exp_rd);
    endtask

    function automatic req_t mk(input logic req, input logic lock, input int addr,
                                input logic [0:3] we, input logic [0:31] data);
        req_t r;
        r.req = req; r.lock = lock; r.addr = 17'(addr); r.we = we; r.data = data;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.req  = ($urandom_range(0, 99) < 60);
        r.lock = ($urandom_range(0, 99) < 25);
        r.addr = 17'($urandom_range(0, 31));
        r.we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
        r.data = $urandom;
        return r;
    endfunction

    req_t idle;

    initial begin
        idle = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(8'(a));
        model_reset();

        #25 reset = 1'b0;
        #1;
        check_eq("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check_eq("rst_iop_rvalid", iop_rvalid, 1'b0);
        check_eq("rst_cpu_active", cpu_active, 1'b1);
        #89 reset = 1'b1;
        @(posedge clock); #1;

        step(idle, idle);
        step(idle, idle);
        check_eq("idle_we", obs_we, 4'b0000);

        // CPU-only read of 0x10
        step(mk(1, 0, 'h10, 4'b0000, '0), idle);
        check_eq("rd10_gnt", obs_cgnt, 1'b1);
        check_eq("rd10_data", mem_dout, 32'h1234_5678);
        check_eq("rd10_iop_rvalid", iop_rvalid, 1'b0);

        // Both requesting continuously: IOP x4, then CPU, repeating
        for (int k = 0; k < 10; k++) begin
            step(mk(1, 0, 'h3, 4'b0000, '0), mk(1, 0, 'h4, 4'b0000, '0));
            check_eq("starve_seq", obs_cgnt, (k % 5) == 4);
        end

        // CPU write against IOP read: IOP first, CPU write next cycle, then readback
        step(mk(1, 0, 'h20, 4'b1111, 32'hDEAD_BEEF), mk(1, 0, 'h21, 4'b0000, '0));
        check_eq("wr_iop_first", obs_ignt, 1'b1);
        check_eq("wr_no_cpu_we", obs_we, 4'b0000);
        step(mk(1, 0, 'h20, 4'b1111, 32'hDEAD_BEEF), idle);
        check_eq("wr_cpu_gnt", obs_cgnt, 1'b1);
        check_eq("wr_we", obs_we, 4'b1111);
        check_eq("wr_addr", obs_addr, 17'h20);
        step(mk(1, 0, 'h20, 4'b0000, '0), idle);
        check_eq("wr_readback", mem_dout, 32'hDEAD_BEEF);

        // CPU lock held for three grants while IOP waits
        step(mk(1, 1, 'h7, 4'b0000, '0), idle);
        check_eq("lock_g1", obs_cgnt, 1'b1);
        step(mk(1, 1, 'h7, 4'b0001, 32'h0000_00AA), mk(1, 0, 'h8, 4'b0000, '0));
        check_eq("lock_g2", obs_cgnt, 1'b1);
        step(mk(1, 1, 'h7, 4'b0000, '0), mk(1, 0, 'h8, 4'b0000, '0));
        check_eq("lock_g3", obs_cgnt, 1'b1);
        step(idle, mk(1, 0, 'h8, 4'b0000, '0));
        check_eq("lock_release_iop", obs_ignt, 1'b1);

        // Reset while an IOP rvalid is pending
        step(mk(1, 0, 'h9, 4'b0000, '0), mk(1, 0, 'h5, 4'b0000, '0));
        check_eq("pre_rst_iop_rvalid", iop_rvalid, 1'b1);
        cpu_req = 1'b0; iop_req = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("async_rst_iop_rvalid", iop_rvalid, 1'b0);
        check_eq("async_rst_cpu_active", cpu_active, 1'b1);
        model_reset();
        @(posedge clock); @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            step(mk(1, 0, 'h1, 4'b0000, '0), mk(1, 0, 'h2, 4'b0000, '0));
            check_eq("post_rst_starve", obs_cgnt, k == 4);
        end

        for (int k = 0; k < 400; k++) step(rnd_req(), rnd_req());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
